// File: rtl/fp_add_responder.sv
// Multi-cycle floating-point adder: one request accepted in IDLE, walked through
// ALIGN/ADD/NORMALIZE/ROUND, result presented with a one-cycle ready pulse in DONE.
module fp_add_responder #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            add_start,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_a,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_b,
    output logic [EXP_LEN+MANTISSA_LEN:0]   add_sum,
    output logic                            add_ready,
    output logic                            add_busy
);
    localparam int W  = EXP_LEN + MANTISSA_LEN + 1;
    localparam int SW = MANTISSA_LEN + 4;   // hidden bit, fraction, guard, round, sticky
    localparam int XW = EXP_LEN + 2;        // exponent with headroom for carry and underflow
    localparam int LW = $clog2(SW + 1);
    localparam logic [EXP_LEN-1:0]        EXP_MAX   = '1;
    localparam logic [EXP_LEN-1:0]        SHIFT_MAX = EXP_LEN'(SW - 1);
    localparam logic signed [XW-1:0]      ONE_X     = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]              QNAN      = {1'b0, EXP_MAX, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORMALIZE, ROUND, DONE} state_t;
    state_t state, state_next;

    logic [W-1:0]              op_a, op_b;
    logic                      sign_a, sign_b, sign_l, swap;
    logic [EXP_LEN-1:0]        exp_a, exp_b, exp_l, exp_s, exp_diff;
    logic [MANTISSA_LEN-1:0]   frac_a, frac_b;
    logic                      nan_a, nan_b, inf_a, inf_b, spec;
    logic [W-1:0]              spec_val;
    logic [W-2:0]              mag_a, mag_b, mag_l, mag_s;
    logic [SW-1:0]             sig_l, sig_s, sig_s_al;
    logic [2*SW-1:0]           shift_ext;

    logic                      sign_p0, sub_p0, spec_p0;
    logic [EXP_LEN-1:0]        exp_p0;
    logic [SW-1:0]             sig_l_p0, sig_s_p0;
    logic [W-1:0]              spec_val_p0;
    logic [SW:0]               sum_p1;
    logic [SW-1:0]             sig_p2, norm_sig;
    logic signed [XW-1:0]      exp_p2, norm_exp, exp_r;
    logic                      zero_p2;
    logic [LW-1:0]             lz;
    logic [MANTISSA_LEN+1:0]   mant_r;
    logic [MANTISSA_LEN-1:0]   frac_r;
    logic [W-1:0]              result;

    function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) n = LW'(SW - 1 - i);
        return n;
    endfunction

    function automatic logic [MANTISSA_LEN+1:0] round_rne(input logic [SW-1:0] sig);
        logic up;
        up = sig[2] & (sig[1] | sig[0] | sig[3]);
        return {1'b0, sig[SW-1:3]} + {{(MANTISSA_LEN+1){1'b0}}, up};
    endfunction

    function automatic logic [W-1:0] pack(input logic sign, input logic signed [XW-1:0] e,
                                          input logic [MANTISSA_LEN-1:0] f);
        if (e >= $signed({2'b00, EXP_MAX}))
            return {sign, EXP_MAX, {MANTISSA_LEN{1'b0}}};
        if (e[XW-1] || e == '0)
            return {sign, {(W-1){1'b0}}};
        return {sign, e[EXP_LEN-1:0], f};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        add_ready  = 1'b0;
        add_busy   = 1'b0;
        case (state)
            IDLE:      if (add_start) state_next = ALIGN;
            ALIGN:     begin state_next = ADD;       add_busy = 1'b1; end
            ADD:       begin state_next = NORMALIZE; add_busy = 1'b1; end
            NORMALIZE: begin state_next = ROUND;     add_busy = 1'b1; end
            ROUND:     begin state_next = DONE;      add_busy = 1'b1; end
            DONE:      begin state_next = IDLE;      add_ready = 1'b1; end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a    <= '0;
            op_b    <= '0;
            add_sum <= '0;
        end else begin
            if (state == IDLE && add_start) begin
                op_a <= add_a;
                op_b <= add_b;
            end
            if (state == ROUND) add_sum <= result;
        end
    end

    // ALIGN: classify, order by magnitude, shift the smaller significand
    assign sign_a = op_a[W-1];
    assign sign_b = op_b[W-1];
    assign exp_a  = op_a[W-2:MANTISSA_LEN];
    assign exp_b  = op_b[W-2:MANTISSA_LEN];
    assign frac_a = op_a[MANTISSA_LEN-1:0];
    assign frac_b = op_b[MANTISSA_LEN-1:0];
    assign nan_a  = (exp_a == EXP_MAX) && (frac_a != '0);
    assign nan_b  = (exp_b == EXP_MAX) && (frac_b != '0);
    assign inf_a  = (exp_a == EXP_MAX) && (frac_a == '0);
    assign inf_b  = (exp_b == EXP_MAX) && (frac_b == '0);
    assign spec   = nan_a | nan_b | inf_a | inf_b;

    always_comb begin
        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) spec_val = QNAN;
        else if (inf_a) spec_val = {sign_a, EXP_MAX, {MANTISSA_LEN{1'b0}}};
        else            spec_val = {sign_b, EXP_MAX, {MANTISSA_LEN{1'b0}}};
    end

    assign mag_a     = (exp_a == '0) ? '0 : op_a[W-2:0];
    assign mag_b     = (exp_b == '0) ? '0 : op_b[W-2:0];
    assign swap      = mag_b > mag_a;
    assign mag_l     = swap ? mag_b : mag_a;
    assign mag_s     = swap ? mag_a : mag_b;
    assign sign_l    = swap ? sign_b : sign_a;
    assign exp_l     = mag_l[W-2:MANTISSA_LEN];
    assign exp_s     = mag_s[W-2:MANTISSA_LEN];
    assign sig_l     = {exp_l != '0, mag_l[MANTISSA_LEN-1:0], 3'b000};
    assign sig_s     = {exp_s != '0, mag_s[MANTISSA_LEN-1:0], 3'b000};
    assign exp_diff  = exp_l - exp_s;
    assign shift_ext = {sig_s, {SW{1'b0}}} >> exp_diff;

    always_comb begin
        if (exp_diff >= SHIFT_MAX)
            sig_s_al = {{(SW-1){1'b0}}, |sig_s};
        else
            sig_s_al = {shift_ext[2*SW-1:SW+1], shift_ext[SW] | (|shift_ext[SW-1:0])};
    end

    always_ff @(posedge clk) begin
        if (state == ALIGN) begin
            sign_p0     <= sign_l;
            sub_p0      <= sign_a ^ sign_b;
            exp_p0      <= exp_l;
            sig_l_p0    <= sig_l;
            sig_s_p0    <= sig_s_al;
            spec_p0     <= spec;
            spec_val_p0 <= spec_val;
        end
        // ADD: magnitude-ordered operands make the difference non-negative
        if (state == ADD)
            sum_p1 <= sub_p0 ? ({1'b0, sig_l_p0} - {1'b0, sig_s_p0})
                             : ({1'b0, sig_l_p0} + {1'b0, sig_s_p0});
        // NORMALIZE: carry shifts right, otherwise leading zeros shift left
        if (state == NORMALIZE) begin
            sig_p2  <= norm_sig;
            exp_p2  <= norm_exp;
            zero_p2 <= (sum_p1 == '0);
        end
    end

    assign lz = lzc(sum_p1[SW-1:0]);

    always_comb begin
        if (sum_p1[SW]) begin
            norm_sig = {sum_p1[SW:2], sum_p1[1] | sum_p1[0]};
            norm_exp = $signed({2'b00, exp_p0}) + ONE_X;
        end else begin
            norm_sig = sum_p1[SW-1:0] << lz;
            norm_exp = $signed({2'b00, exp_p0}) - $signed({{(XW-LW){1'b0}}, lz});
        end
    end

    // ROUND: nearest-even, then range checks
    assign mant_r = round_rne(sig_p2);
    assign exp_r  = mant_r[MANTISSA_LEN+1] ? exp_p2 + ONE_X : exp_p2;
    assign frac_r = mant_r[MANTISSA_LEN+1] ? mant_r[MANTISSA_LEN:1] : mant_r[MANTISSA_LEN-1:0];

    always_comb begin
        if (spec_p0)      result = spec_val_p0;
        else if (zero_p2) result = {sign_p0 & ~sub_p0, {(W-1){1'b0}}};
        else              result = pack(sign_p0, exp_r, frac_r);
    end

endmodule

// File: tb/tb_fp_add_responder.sv
// Directed bench for fp_add_responder: arithmetic vectors, latency, start
// filtering, back-to-back throughput and mid-flight reset.
module tb_fp_add_responder;
    logic        clk;
    logic        reset;
    logic        add_start;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_ready, add_busy;

    int total = 0;
    int bad   = 0;

    fp_add_responder dut (
        .clk       (clk),
        .reset     (reset),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_ready (add_ready),
        .add_busy  (add_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One request; ready must appear on the 4th edge after acceptance (DONE is the 5th cycle).
    task automatic do_add(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input logic [31:0] prev);
        int n;
        @(negedge clk);
        add_a = a; add_b = b; add_start = 1'b1;
        @(posedge clk); #1;
        add_start = 1'b0;
        chk({tag, "_busy"}, {31'b0, add_busy}, 32'd1);
        chk({tag, "_hold"}, add_sum, prev);
        n = 0;
        while (!add_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 32'd4);
        chk({tag, "_sum"}, add_sum, want);
        chk({tag, "_rdybusy"}, {31'b0, add_busy}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'b0, add_ready}, 32'd0);
    endtask

    initial begin
        int n;
        int hits;
        reset = 1'b0; add_start = 1'b0; add_a = '0; add_b = '0;
        #2;
        chk("rst_sum",   add_sum, 32'h0);
        chk("rst_ready", {31'b0, add_ready}, 32'd0);
        chk("rst_busy",  {31'b0, add_busy}, 32'd0);
        #5 reset = 1'b1;

        do_add("one_one",  32'h3F800000, 32'h3F800000, 32'h40000000, 32'h00000000);
        do_add("sev_six",  32'h40E00000, 32'hC0C00000, 32'h3F800000, 32'h40000000);
        do_add("cancel",   32'h3F800000, 32'hBF800000, 32'h00000000, 32'h3F800000);
        do_add("tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000, 32'h00000000);
        do_add("tie_odd",  32'h3F800001, 32'h33800000, 32'h3F800002, 32'h3F800000);
        do_add("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800002);
        do_add("inf_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800000);
        do_add("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000);
        do_add("neg_zero", 32'h80000000, 32'h80000000, 32'h80000000, 32'h7FC00000);
        do_add("ninf_fin", 32'hFF800000, 32'h3F800000, 32'hFF800000, 32'h80000000);
        do_add("denorm",   32'h80000001, 32'h80000000, 32'h80000000, 32'hFF800000);
        do_add("den_one",  32'h007FFFFF, 32'h3F800000, 32'h3F800000, 32'h80000000);

        // Start held with new operands while busy must not disturb the first result,
        // and the still-high start is taken in the IDLE cycle after DONE.
        @(negedge clk);
        add_a = 32'h3F800000; add_b = 32'h3F800000; add_start = 1'b1;
        @(posedge clk); #1;
        add_a = 32'h40E00000; add_b = 32'hC0C00000;
        n = 0;
        while (!add_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_lat", n, 32'd4);
        chk("ign_sum", add_sum, 32'h40000000);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!add_ready && n < 12);
        add_start = 1'b0;
        chk("b2b_gap", n, 32'd6);
        chk("b2b_sum", add_sum, 32'h3F800000);

        // Reset while in NORMALIZE
        @(negedge clk);
        add_a = 32'h3F800000; add_b = 32'h3F800000; add_start = 1'b1;
        @(posedge clk); #1;
        add_start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'b0, add_busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, add_ready}, 32'd0);
        chk("mid_rst_sum",   add_sum, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        hits = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (add_ready) hits++;
        end
        chk("mid_rst_noready", hits, 32'd0);
        do_add("after_rst", 32'h40E00000, 32'hC0C00000, 32'h3F800000, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
